alu_req_arbiter: RTL and testbench

Sequencer and arbiter that shares the single 8-bit ALU between two requesters (e.g. a host port and a microcode engine). It accepts opcode/operand requests with a valid/ready handshake and grants them round-robin. It drives the ALU's enable/input_ready strobe, waits for result_ready with a timeout, and returns the result, flags and requester id on a response channel. It keeps a per-requester carry and borrow flag so multi-byte CADD/BSUB chains from one requester are not corrupted by the other.

---
 rtl/alu_req_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one 8-bit ALU between two requesters with round-robin grant
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid[1:0], req_ready[1:0] request handshake, bit i = requester i
//   req_opcode[9:0]               {req1 opcode, req0 opcode}, 5 bits each
//   req_a[15:0], req_b[15:0]      {req1 operand, req0 operand}, 8 bits each
//   resp_valid, resp_ready        response handshake
//   resp_id, resp_result, resp_flags, resp_err   response payload
//   alu_enable, alu_input_ready   one-cycle issue strobe to the ALU
//   alu_opcode, alu_a, alu_b      latched operation
//   alu_carry_in, alu_borrow_in   granted requester's stored carry/borrow
//   alu_result, alu_result_ready, alu_flags      ALU return path
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie
// (requester 1 can then starve); otherwise ties alternate round-robin.
module alu_req_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int NUM_OPS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [9:0]  req_opcode,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [7:0]  resp_result,
   output logic [5:0]  resp_flags,
   output logic        resp_err,
   output logic        alu_enable,
   output logic        alu_input_ready,
   output logic [4:0]  alu_opcode,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_carry_in,
   output logic        alu_borrow_in,
   input  logic [7:0]  alu_result,
   input  logic        alu_result_ready,
   input  logic [5:0]  alu_flags
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
   localparam logic [5:0] NOPS = 6'(NUM_OPS);
   logic [1:0] state;
   logic id, last_grant, gnt, legal;
   logic [1:0] carry_reg, borrow_reg;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [4:0] op_sel;
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign gnt = ~req_valid[0];
`else
   // on a tie the requester that was not served last goes next
   assign gnt = &req_valid ? ~last_grant : req_valid[1];
`endif
   assign op_sel = gnt ? req_opcode[9:5] : req_opcode[4:0];
   assign legal = {1'b0, op_sel} < NOPS;
   assign cnt_nxt = cnt + 1'b1;
   assign req_ready = (!rst && state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign resp_valid = state == RESP;
   assign resp_id = id;
   assign alu_enable = state == ISSUE;
   assign alu_input_ready = state == ISSUE;
   assign alu_carry_in = carry_reg[id];
   assign alu_borrow_in = borrow_reg[id];
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         id          <= 1'b0;
         last_grant  <= 1'b1;
         carry_reg   <= 2'b00;
         borrow_reg  <= 2'b00;
         cnt         <= '0;
         alu_opcode  <= 5'd0;
         alu_a       <= 8'd0;
         alu_b       <= 8'd0;
         resp_result <= 8'd0;
         resp_flags  <= 6'd0;
         resp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               id          <= gnt;
               alu_opcode  <= op_sel;
               alu_a       <= gnt ? req_a[15:8] : req_a[7:0];
               alu_b       <= gnt ? req_b[15:8] : req_b[7:0];
               resp_result <= 8'd0;
               resp_flags  <= 6'd0;
               resp_err    <= ~legal;
               state       <= legal ? ISSUE : RESP;
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            // a result arriving on the timeout cycle still wins
            WAIT: if (alu_result_ready) begin
               resp_result <= alu_result;
               resp_flags  <= alu_flags;
               state       <= RESP;
            end else if (cnt_nxt == TLAST) begin
               resp_err <= 1'b1;
               state    <= RESP;
            end else begin
               cnt <= cnt_nxt;
            end
            RESP: if (resp_ready) begin
               if (!resp_err) begin
                  carry_reg[id]  <= resp_flags[0];
                  borrow_reg[id] <= resp_flags[1];
               end
               last_grant <= id;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed scoreboard bench for alu_req_arbiter
module tb_alu_req_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [9:0] req_opcode = 10'd0;
   logic [15:0] req_a = 16'd0, req_b = 16'd0;
   logic resp_valid, resp_ready = 1'b0, resp_id, resp_err;
   logic [7:0] resp_result;
   logic [5:0] resp_flags;
   logic alu_enable, alu_input_ready, alu_carry_in, alu_borrow_in;
   logic [4:0] alu_opcode;
   logic [7:0] alu_a, alu_b, alu_result;
   logic alu_result_ready;
   logic [5:0] alu_flags;
   logic [8:0] sum;
   int n_cmp = 0, n_err = 0, alu_mode = 1, cd = 0, strobes = 0;
   logic [15:0] sb[$];
   always #5 clk = ~clk;
   alu_req_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
      .alu_enable(alu_enable), .alu_input_ready(alu_input_ready),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_carry_in(alu_carry_in), .alu_borrow_in(alu_borrow_in),
      .alu_result(alu_result), .alu_result_ready(alu_result_ready), .alu_flags(alu_flags)
   );
   // ALU stand-in: 0 ADD, 1 CADD, 2 AND, 3 OR; answers alu_mode cycles after the strobe (0 = never)
   always_comb begin
      sum = 9'd0;
      case (alu_opcode)
         5'd0: sum = {1'b0, alu_a} + {1'b0, alu_b};
         5'd1: sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
         5'd2: sum = {1'b0, alu_a & alu_b};
         5'd3: sum = {1'b0, alu_a | alu_b};
         default: sum = 9'd0;
      endcase
   end
   assign alu_result = sum[7:0];
   assign alu_flags = {^sum[7:0], 1'b0, sum[7], sum[7:0] == 8'd0, 1'b0, sum[8]};
   always @(posedge clk) begin
      if (alu_enable) begin
         strobes <= strobes + 1;
         cd <= alu_mode;
      end else if (cd != 0) cd <= cd - 1;
   end
   assign alu_result_ready = cd == 1;
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [15:0] ex(input logic id, input logic [7:0] r, input logic [5:0] f, input logic e);
      return {id, r, f, e};
   endfunction
   task automatic drive(input int r, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[r] = 1'b1;
      req_opcode[r*5 +: 5] = op;
      req_a[r*8 +: 8] = a;
      req_b[r*8 +: 8] = b;
   endtask
   task automatic grant(input int r, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
      drive(r, op, a, b);
      #1;
      check("grant", {30'd0, req_ready}, 32'd1 << r);
      sb.push_back(e);
      step();
      req_valid[r] = 1'b0;
   endtask
   task automatic wait_resp(input int max, output int n);
      logic [15:0] e;
      n = 0;
      while (!resp_valid && n < max) begin
         step();
         n++;
      end
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      if (resp_valid) begin
         check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
         e = sb.size() != 0 ? sb.pop_front() : 16'hxxxx;
         check("resp_id", {31'd0, resp_id}, {31'd0, e[15]});
         check("resp_result", {24'd0, resp_result}, {24'd0, e[14:7]});
         check("resp_flags", {26'd0, resp_flags}, {26'd0, e[6:1]});
         check("resp_err", {31'd0, resp_err}, {31'd0, e[0]});
         check("no_grant_in_resp", {30'd0, req_ready}, 32'd0);
         resp_ready = 1'b1;
         step();
         resp_ready = 1'b0;
         check("resp_done", {31'd0, resp_valid}, 32'd0);
      end
   endtask
   initial begin
      int n, s0, seen, first;
      logic [7:0] rr_res [2];
      logic [5:0] rr_flg [2];
      step();
      step();
      check("rst_req_ready", {30'd0, req_ready}, 32'd0);
      check("rst_resp", {16'd0, resp_valid, resp_id, resp_err, resp_result, resp_flags[4:0]}, 32'd0);
      check("rst_alu", {12'd0, alu_enable, alu_input_ready, alu_opcode, alu_a[3:0], alu_b, alu_carry_in, alu_borrow_in}, 32'd0);
      check("rst_flags", {26'd0, resp_flags}, 32'd0);
      rst = 1'b0;
      // simultaneous requests right after reset: req0 first, then req1
      drive(0, 5'd2, 8'hF0, 8'h3C);
      drive(1, 5'd3, 8'h0F, 8'hF0);
      #1;
      check("tie_after_reset", {30'd0, req_ready}, 32'd1);
      sb.push_back(ex(1'b0, 8'h30, 6'b000000, 1'b0));
      step();
      req_valid[0] = 1'b0;
      wait_resp(10, n);
      check("req1_next", {30'd0, req_ready}, 32'd2);
      sb.push_back(ex(1'b1, 8'hFF, 6'b001000, 1'b0));
      step();
      req_valid[1] = 1'b0;
      wait_resp(10, n);
      // single ADD with minimum latency
      grant(0, 5'd0, 8'h05, 8'h03, ex(1'b0, 8'h08, 6'b100000, 1'b0));
      check("strobe", {30'd0, alu_enable, alu_input_ready}, 32'd3);
      check("alu_ops", {11'd0, alu_opcode, alu_a, alu_b}, {11'd0, 5'd0, 8'h05, 8'h03});
      check("cin_borrow", {30'd0, alu_carry_in, alu_borrow_in}, 32'd0);
      wait_resp(10, n);
      check("min_latency", n, 2);
      // tie after req0 was served last
`ifdef ALU_ARB_FIXED_PRIO_EN
      first = 0;
`else
      first = 1;
`endif
      rr_res[0] = 8'h03; rr_flg[0] = 6'b000000;
      rr_res[1] = 8'h81; rr_flg[1] = 6'b001000;
      drive(0, 5'd3, 8'h01, 8'h02);
      drive(1, 5'd2, 8'hFF, 8'h81);
      #1;
      check("tie_rr", {30'd0, req_ready}, 32'd1 << first);
      sb.push_back(ex(first[0], rr_res[first], rr_flg[first], 1'b0));
      step();
      req_valid[first] = 1'b0;
      wait_resp(10, n);
      check("tie_rr_second", {30'd0, req_ready}, 32'd1 << (1 - first));
      sb.push_back(ex(~first[0], rr_res[1-first], rr_flg[1-first], 1'b0));
      step();
      req_valid[1-first] = 1'b0;
      wait_resp(10, n);
      // carry stays per requester
      grant(0, 5'd0, 8'hFF, 8'h01, ex(1'b0, 8'h00, 6'b000101, 1'b0));
      wait_resp(10, n);
      grant(1, 5'd1, 8'h01, 8'h01, ex(1'b1, 8'h02, 6'b100000, 1'b0));
      check("cin_req1", {31'd0, alu_carry_in}, 32'd0);
      wait_resp(10, n);
      grant(0, 5'd1, 8'h01, 8'h01, ex(1'b0, 8'h03, 6'b000000, 1'b0));
      check("cin_req0", {31'd0, alu_carry_in}, 32'd1);
      wait_resp(10, n);
      // timeout keeps the stored carry
      grant(0, 5'd0, 8'hFF, 8'h01, ex(1'b0, 8'h00, 6'b000101, 1'b0));
      wait_resp(10, n);
      alu_mode = 0;
      grant(0, 5'd0, 8'h12, 8'h34, ex(1'b0, 8'h00, 6'b000000, 1'b1));
      check("to_strobe", {31'd0, alu_enable}, 32'd1);
      wait_resp(40, n);
      check("timeout_latency", n, 16);
      alu_mode = 1;
      grant(0, 5'd1, 8'h01, 8'h01, ex(1'b0, 8'h03, 6'b000000, 1'b0));
      check("cin_after_to", {31'd0, alu_carry_in}, 32'd1);
      wait_resp(10, n);
      check("after_to_latency", n, 2);
      // illegal opcode never strobes the ALU
      s0 = strobes;
      grant(1, 5'd25, 8'hAA, 8'h55, ex(1'b1, 8'h00, 6'b000000, 1'b1));
      check("illegal_no_strobe", {31'd0, alu_enable}, 32'd0);
      wait_resp(5, n);
      check("illegal_strobes", strobes, s0);
      // consumer stalls for 5 cycles
      grant(0, 5'd2, 8'hF0, 8'h3C, ex(1'b0, 8'h30, 6'b000000, 1'b0));
      step();
      step();
      drive(1, 5'd0, 8'h01, 8'h01);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_hold", {22'd0, resp_valid, resp_id, resp_result}, {22'd0, 1'b1, 1'b0, 8'h30});
         check("stall_no_grant", {30'd0, req_ready}, 32'd0);
         step();
      end
      req_valid[1] = 1'b0;
      wait_resp(5, n);
      check("stall_immediate", n, 0);
      // reset while waiting drops the transaction
      alu_mode = 0;
      drive(0, 5'd0, 8'h05, 8'h03);
      step();
      req_valid[0] = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("wait_rst_out", {13'd0, req_ready, resp_valid, alu_enable, alu_input_ready, alu_opcode, alu_a[3:0], alu_carry_in, alu_borrow_in, resp_err}, 32'd0);
      check("wait_rst_a", {24'd0, alu_a}, 32'd0);
      rst = 1'b0;
      alu_mode = 1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (resp_valid) seen++;
      end
      check("no_resp_after_rst", seen, 0);
      grant(0, 5'd0, 8'h05, 8'h03, ex(1'b0, 8'h08, 6'b100000, 1'b0));
      wait_resp(10, n);
      check("post_rst_latency", n, 2);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
